alu_arbiter: RTL and testbench

- Shares the single combinational 32-bit ALU between NUM_REQ requesters, e.g. execute stage and branch/address unit.
- Round-robin grant, registered operands, registered result.
- Valid/ready handshake on both the request side and the response side.
- Sits between the requesters and the ALU instance. Drives the ALU operand and opcode inputs and samples its result and isEqual outputs.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding, the legal-opcode
// bound and the arbiter state encoding.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_XOR  = 4'd4;
  localparam alu_op_t ALU_SLL  = 4'd5;
  localparam alu_op_t ALU_SRL  = 4'd6;
  localparam alu_op_t ALU_SRA  = 4'd7;
  localparam alu_op_t ALU_SLT  = 4'd8;
  localparam alu_op_t ALU_SLTU = 4'd9;

  localparam alu_op_t ALU_OP_LAST = ALU_SLTU;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_EXEC = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  function automatic logic alu_op_illegal(input alu_op_t op);
    return op > ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// ptr_i (wrapping), returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant_o[IDX_W'(cand)] = 1'b1;
        idx_o                 = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: IDLE -> EXEC -> RESP.
// Optional ALU_ARB_PERF_EN adds perf_ops / perf_wait counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_is_equal,
  output logic                    rsp_err,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [ALU_OP_W-1:0]     alu_op,
  input  logic [XLEN-1:0]         alu_result,
  input  logic                    alu_is_equal
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_wait
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [XLEN-1:0] req_a_arr  [NUM_REQ];
  logic [XLEN-1:0] req_b_arr  [NUM_REQ];
  alu_op_t         req_op_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a_arr[gi]  = req_a[gi*XLEN +: XLEN];
    assign req_b_arr[gi]  = req_b[gi*XLEN +: XLEN];
    assign req_op_arr[gi] = req_op[gi*ALU_OP_W +: ALU_OP_W];
  end

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
  alu_op_t            op_q, op_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               eq_q, eq_d, err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign req_ready = (state_q == ARB_IDLE) ? grant : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    eq_d        = eq_q;
    err_d       = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          a_d      = req_a_arr[win_idx];
          b_d      = req_b_arr[win_idx];
          op_d     = req_op_arr[win_idx];
          rr_ptr_d = win_idx;
          owner_d  = win_idx;
          state_d  = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        // Illegal codes still reach the ALU, but its answer is discarded.
        if (alu_op_illegal(op_q)) begin
          result_d = '0;
          eq_d     = 1'b0;
          err_d    = 1'b1;
        end else begin
          result_d = alu_result;
          eq_d     = alu_is_equal;
          err_d    = 1'b0;
        end
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = ARB_RESP;
      end
      ARB_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= '0;
      result_q    <= '0;
      eq_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
      err_q       <= err_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_is_equal = eq_q;
  assign rsp_err      = err_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      if (state_q == ARB_RESP && rsp_ready[owner_q]) perf_ops_q <= perf_ops_q + 32'd1;
      if (|req_valid && req_ready == '0) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_wait = perf_wait_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, table-driven vectors,
// scoreboard of expected responses, and hand-written multi-cycle sequences.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*XL-1:0] req_a, req_b;
  logic [N*4-1:0]  req_op;
  logic [XL-1:0]   rsp_result, alu_a, alu_b, alu_result;
  logic            rsp_is_equal, rsp_err, alu_is_equal;
  logic [3:0]      alu_op;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]     perf_ops, perf_wait;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_is_equal (rsp_is_equal),
    .rsp_err      (rsp_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_is_equal (alu_is_equal)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops     (perf_ops),
    .perf_wait    (perf_wait)
`endif
  );

  // Behavioural ALU; the unknown-op value must never reach rsp_result.
  always_comb begin
    alu_is_equal = (alu_a == alu_b);
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = alu_a << alu_b[4:0];
      4'd6:    alu_result = alu_a >> alu_b[4:0];
      4'd7:    alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'd8:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd9:    alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        eq;
    logic        err;
  } vec_t;

  typedef struct {
    int          req;
    logic [31:0] res;
    logic        eq;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks   = 0;
  int   errors   = 0;
  int   hs_cnt   = 0;
  int   wait_cnt = 0;
  vec_t tbl[12];

  function automatic vec_t mk(input int r, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [31:0] res,
                              input logic eq, input logic err);
    vec_t v;
    v.req = r; v.a = a; v.b = b; v.op = op; v.res = res; v.eq = eq; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request, wait for its accept pulse, record the expected response.
  task automatic drive(input vec_t v);
    exp_t e;
    bit   got = 1'b0;
    req_a[v.req*XL +: XL] = v.a;
    req_b[v.req*XL +: XL] = v.b;
    req_op[v.req*4 +: 4]  = v.op;
    req_valid[v.req]      = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (req_ready[v.req]) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      e.req = v.req; e.res = v.res; e.eq = v.eq; e.err = v.err;
      sb.push_back(e);
      grant_log.push_back(v.req);
      $display("grant   req%0d a=%08h b=%08h op=%0d", v.req, v.a, v.b, v.op);
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: req%0d never saw req_ready", v.req);
    end
    req_valid[v.req] = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_valid != '0) begin
          chk("grant_onehot", 32'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
          if (req_ready == '0) wait_cnt++;
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
          end else begin
            e = sb.pop_front();
            $display("resp    req%0d result=%08h eq=%0b err=%0b", e.req, rsp_result, rsp_is_equal, rsp_err);
            chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.req));
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_is_equal", 32'(rsp_is_equal), 32'(e.eq));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            hs_cnt++;
          end
        end
      end
    end
  endtask

  // Wait until every accepted op has been answered; ends at posedge+1.
  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && rsp_valid == '0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) @(negedge clk);
    sb.delete();
    hs_cnt   = 0;
    wait_cnt = 0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_is_equal"}, 32'(rsp_is_equal), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(0, 32'h0000_0007, 32'h0000_0007, 4'd1, 32'h0000_0000, 1'b1, 1'b0);
    tbl[1]  = mk(1, 32'hF0F0_FFFF, 32'h0FF0_00FF, 4'd2, 32'h00F0_00FF, 1'b0, 1'b0);
    tbl[2]  = mk(0, 32'h1200_0000, 32'h0000_0034, 4'd3, 32'h1200_0034, 1'b0, 1'b0);
    tbl[3]  = mk(1, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd4, 32'hF0F0_0F0F, 1'b0, 1'b0);
    tbl[4]  = mk(0, 32'h8000_0000, 32'h0000_0004, 4'd6, 32'h0800_0000, 1'b0, 1'b0);
    tbl[5]  = mk(1, 32'hFFFF_FFF8, 32'h0000_0002, 4'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tbl[6]  = mk(0, 32'hFFFF_FFFF, 32'h0000_0009, 4'd8, 32'h0000_0001, 1'b0, 1'b0);
    tbl[7]  = mk(1, 32'hFFFF_FFFF, 32'h0000_0009, 4'd9, 32'h0000_0000, 1'b0, 1'b0);
    tbl[8]  = mk(0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 32'h0000_0000, 1'b0, 1'b0);
    tbl[9]  = mk(0, 32'h0000_0005, 32'h0000_0007, 4'd12, 32'h0000_0000, 1'b0, 1'b1);
    tbl[10] = mk(1, 32'h0000_0007, 32'h0000_0007, 4'd15, 32'h0000_0000, 1'b0, 1'b1);
    tbl[11] = mk(0, 32'h0000_0001, 32'h0000_0001, 4'd5, 32'h0000_0002, 1'b1, 1'b0);

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '1;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef ALU_ARB_PERF_EN
    chk("perf_ops_reset", perf_ops, 32'd0);
    chk("perf_wait_reset", perf_wait, 32'd0);
`endif

    // Contention straight after reset: requester 0 first, then 1
    grant_log.delete();
    fork
      drive(mk(0, 32'd66, 32'd11, 4'd1, 32'd55, 1'b0, 1'b0));
      drive(mk(1, 32'd1, 32'd3, 4'd5, 32'd8, 1'b0, 1'b0));
    join
    drain();
    chk("contA_first", grant_log.size() > 0 ? grant_log[0] : -1, 32'd0);
    chk("contA_second", grant_log.size() > 1 ? grant_log[1] : -1, 32'd1);

    // Single request with accept-to-response latency of two edges
    drive(mk(0, 32'd5, 32'd5, 4'd0, 32'd10, 1'b1, 1'b0));
    chk("lat_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("lat_exec_alu_a", alu_a, 32'd5);
    chk("lat_exec_alu_b", alu_b, 32'd5);
    chk("lat_exec_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_rsp_result", rsp_result, 32'd10);
    drain();

    // Requester 0 was last served, so requester 1 now wins
    grant_log.delete();
    fork
      drive(mk(0, 32'd66, 32'd11, 4'd1, 32'd55, 1'b0, 1'b0));
      drive(mk(1, 32'd1, 32'd3, 4'd5, 32'd8, 1'b0, 1'b0));
    join
    drain();
    chk("contB_first", grant_log.size() > 0 ? grant_log[0] : -1, 32'd1);
    chk("contB_second", grant_log.size() > 1 ? grant_log[1] : -1, 32'd0);

    // Table of single operations, including illegal opcodes
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      drain();
    end

    // Back-pressure on requester 1 while requester 0 waits
    grant_log.delete();
    rsp_ready[1] = 1'b0;
    drive(mk(1, 32'hFFFF_FFF8, 32'd2, 4'd7, 32'hFFFF_FFFE, 1'b0, 1'b0));
    fork
      drive(mk(0, 32'd3, 32'd4, 4'd0, 32'd7, 1'b0, 1'b0));
      begin
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_rsp_valid", 32'(rsp_valid), 32'd2);
          chk("bp_rsp_result", rsp_result, 32'hFFFF_FFFE);
          chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
      end
    join
    drain();
    chk("bp_first", grant_log.size() > 0 ? grant_log[0] : -1, 32'd1);
    chk("bp_second", grant_log.size() > 1 ? grant_log[1] : -1, 32'd0);

    // Reset during EXEC discards the op
    drive(mk(0, 32'hFFFF_FFFF, 32'd9, 4'd8, 32'd1, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb.delete();
    hs_cnt   = 0;
    wait_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      drive(mk(0, 32'd2, 32'd3, 4'd0, 32'd5, 1'b0, 1'b0));
      drive(mk(1, 32'd9, 32'd3, 4'd1, 32'd6, 1'b0, 1'b0));
    join
    drain();
    chk("midrst_prio", grant_log.size() > 0 ? grant_log[0] : -1, 32'd0);

    // Three ops after a fresh reset, one waiting behind a stalled response
    do_reset();
    drive(mk(1, 32'd4, 32'd4, 4'd4, 32'd0, 1'b1, 1'b0));
    drain();
    rsp_ready[0] = 1'b0;
    fork
      drive(mk(0, 32'd10, 32'd1, 4'd5, 32'd20, 1'b0, 1'b0));
      drive(mk(1, 32'd3, 32'd8, 4'd8, 32'd1, 1'b0, 1'b0));
      begin
        for (int c = 0; c < 40 && !rsp_valid[0]; c++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        rsp_ready[0] = 1'b1;
      end
    join
    drain();
    chk("perf_seq_ops_seen", hs_cnt, 32'd3);
`ifdef ALU_ARB_PERF_EN
    chk("perf_ops", perf_ops, 32'd3);
    chk("perf_wait_model", perf_wait, wait_cnt);
    chk("perf_wait_min4", 32'(perf_wait >= 32'd4), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
